// File: rtl/button_event_decoder_pkg.sv
// Shared types and elaboration-time helpers for the button event decoder.
// The state encoding is fixed to 3 bits so it can be matched against external traces.
package button_event_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >>> 1;
    end
    return result;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, gesture events out; the decoder uses the slave side.
interface button_event_decoder_if;
  logic enable;
  logic btn_in;
  logic held;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic double_click;

  modport master (
    output enable, btn_in,
    input  held, press_pulse, release_pulse, short_press,
           long_press, repeat_pulse, double_click
  );

  modport slave (
    input  enable, btn_in,
    output held, press_pulse, release_pulse, short_press,
           long_press, repeat_pulse, double_click
  );
endinterface

// File: rtl/button_event_decoder_event_timer.sv
// Saturating cycle counter with synchronous clear and an equality match against
// a caller-supplied value.
module button_event_decoder_event_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_a_p,
  input  logic             clear,
  input  logic [WIDTH-1:0] match_value,
  output logic             match
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst_a_p || clear) begin
      count <= '0;
    end else if (count != {WIDTH{1'b1}}) begin
      count <= count + WIDTH'(1);
    end
  end

  assign match = (count == match_value);

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/short/long/repeat/double-click
// pulses. One shared timer is re-targeted per state; all outputs are registered.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int DCLICK_CYCLES = 12_500_000,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input logic                  clk,
  input logic                  rst_a_p,
  button_event_decoder_if.slave bus
);

  localparam int CNT_W = clog2(max3(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_MATCH   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_MATCH = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_MATCH =
    (DCLICK_CYCLES == 0) ? '0 : CNT_W'(DCLICK_CYCLES - 1);

  logic             b;
  logic             btn_q;
  logic             rise;
  logic             fall;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] match_value;
  logic             timer_match;
  logic             timer_clear;
  logic             repeat_restart;
  logic             press_nxt;
  logic             release_nxt;
  logic             short_nxt;
  logic             long_nxt;
  logic             repeat_nxt;
  logic             dclick_nxt;

  assign b    = ACTIVE_LOW ? ~bus.btn_in : bus.btn_in;
  assign rise = b & ~btn_q;
  assign fall = ~b & btn_q;

  always_comb begin
    match_value = '1;
    case (state)
      ST_PRESSED:     match_value = LONG_MATCH;
      ST_LONG_HELD:   match_value = REPEAT_MATCH;
      ST_WAIT_SECOND: match_value = DCLICK_MATCH;
      default:        match_value = '1;
    endcase
  end

  // The timer restarts on every state change and on each repeat period.
  assign timer_clear = ~bus.enable | (state_nxt != state) | repeat_restart;

  button_event_decoder_event_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_a_p     (rst_a_p),
    .clear       (timer_clear),
    .match_value (match_value),
    .match       (timer_match)
  );

  always_comb begin
    state_nxt      = state;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    short_nxt      = 1'b0;
    long_nxt       = 1'b0;
    repeat_nxt     = 1'b0;
    dclick_nxt     = 1'b0;
    repeat_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_PRESSED;
          press_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        // A release on the threshold cycle still counts as a short press.
        if (fall) begin
          release_nxt = 1'b1;
          if (DCLICK_CYCLES == 0) begin
            short_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_SECOND;
          end
        end else if (b && timer_match) begin
          long_nxt  = 1'b1;
          state_nxt = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (timer_match) begin
          repeat_nxt     = 1'b1;
          repeat_restart = 1'b1;
        end
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_SECOND: begin
        if (rise) begin
          press_nxt  = 1'b1;
          dclick_nxt = 1'b1;
          state_nxt  = ST_SECOND_PRESSED;
        end else if (timer_match) begin
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SECOND_PRESSED: begin
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // btn_q keeps tracking through reset and disable so a held button is never a new press.
  always_ff @(posedge clk) begin
    btn_q <= b;
    if (rst_a_p || !bus.enable) begin
      state             <= ST_IDLE;
      bus.held          <= 1'b0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_press   <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.double_click  <= 1'b0;
    end else begin
      state             <= state_nxt;
      bus.held          <= (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG_HELD) ||
                           (state_nxt == ST_SECOND_PRESSED);
      bus.press_pulse   <= press_nxt;
      bus.release_pulse <= release_nxt;
      bus.short_press   <= short_nxt;
      bus.long_press    <= long_nxt;
      bus.repeat_pulse  <= repeat_nxt;
      bus.double_click  <= dclick_nxt;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: an active-high and an active-low instance see the same
// gestures (inverted level) and are both compared each cycle against a timestamp model.
module tb_button_event_decoder;

  localparam int LC = 8;
  localparam int RC = 4;
  localparam int DC = 6;

  localparam int P_NONE   = 0;
  localparam int P_FIRST  = 1;
  localparam int P_LONG   = 2;
  localparam int P_WAIT   = 3;
  localparam int P_SECOND = 4;

  logic clk;
  logic rst_a_p;

  button_event_decoder_if bus ();
  button_event_decoder_if bus_n ();

  button_event_decoder #(
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .DCLICK_CYCLES(DC), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_a_p(rst_a_p), .bus(bus)
  );

  button_event_decoder #(
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .DCLICK_CYCLES(DC), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst_a_p(rst_a_p), .bus(bus_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: phase of the gesture plus the cycle at which that phase began.
  int         m_phase = P_NONE;
  int         m_t0 = 0;
  logic       m_prev = 1'b0;
  logic [6:0] exp_vec;
  logic [6:0] obs;
  logic [6:0] obs_n;

  int n_press, n_release, n_short, n_long, n_repeat, n_dclick;
  int t_press, t_release, t_short, t_long, t_dclick;

  task automatic reset_tally();
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_repeat = 0; n_dclick = 0;
    t_press = -1; t_release = -1; t_short = -1; t_long = -1; t_dclick = -1;
  endtask

  task automatic model_step(input logic r, input logic en, input logic b);
    logic rise, fall, pp, rp, sp, lp, rep, dcl, hd;
    pp = 0; rp = 0; sp = 0; lp = 0; rep = 0; dcl = 0;
    rise = b && !m_prev;
    fall = !b && m_prev;
    if (r || !en) begin
      m_phase = P_NONE;
    end else begin
      case (m_phase)
        P_NONE: if (rise) begin m_phase = P_FIRST; m_t0 = cyc; pp = 1; end
        P_FIRST: begin
          if (fall) begin
            rp = 1;
            m_phase = P_WAIT;
            m_t0 = cyc;
          end else if (cyc - m_t0 == LC) begin
            lp = 1;
            m_phase = P_LONG;
            m_t0 = cyc;
          end
        end
        P_LONG: begin
          if ((cyc - m_t0) % RC == 0) rep = 1;
          if (fall) begin rp = 1; m_phase = P_NONE; end
        end
        P_WAIT: begin
          if (rise) begin pp = 1; dcl = 1; m_phase = P_SECOND; end
          else if (cyc - m_t0 == DC) begin sp = 1; m_phase = P_NONE; end
        end
        default: if (fall) begin rp = 1; m_phase = P_NONE; end
      endcase
    end
    m_prev = b;
    hd = (m_phase == P_FIRST) || (m_phase == P_LONG) || (m_phase == P_SECOND);
    exp_vec = {hd, pp, rp, sp, lp, rep, dcl};
  endtask

  // Drives one clock of stimulus from the falling edge and samples just after the rising edge.
  task automatic drive_cycle(input logic r, input logic en, input logic b);
    cyc++;
    rst_a_p = r;
    bus.enable = en;
    bus.btn_in = b;
    bus_n.enable = en;
    bus_n.btn_in = ~b;
    model_step(r, en, b);
    @(posedge clk);
    #1;
    obs   = {bus.held, bus.press_pulse, bus.release_pulse, bus.short_press,
             bus.long_press, bus.repeat_pulse, bus.double_click};
    obs_n = {bus_n.held, bus_n.press_pulse, bus_n.release_pulse, bus_n.short_press,
             bus_n.long_press, bus_n.repeat_pulse, bus_n.double_click};
    if (obs[5]) begin n_press++;   t_press = cyc;   end
    if (obs[4]) begin n_release++; t_release = cyc; end
    if (obs[3]) begin n_short++;   t_short = cyc;   end
    if (obs[2]) begin n_long++;    t_long = cyc;    end
    if (obs[1]) n_repeat++;
    if (obs[0]) begin n_dclick++;  t_dclick = cyc;  end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("[TB] FAIL reset_state cyc=%0d got=%b want=%b", cyc, obs, 7'b0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
  endtask

  task automatic test_short_press();
    logic q[$];
    reset_tally();
    repeat (3) q.push_back(1'b1);
    repeat (10) q.push_back(1'b0);
    foreach (q[i]) begin
      drive_cycle(1'b0, 1'b1, q[i]);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL short_trace cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    checks++;
    if (n_press != 1 || n_release != 1 || n_short != 1 || n_long != 0 || n_dclick != 0) begin
      errors++;
      $display("[TB] FAIL short_counts got p%0d r%0d s%0d l%0d d%0d want p1 r1 s1 l0 d0",
               n_press, n_release, n_short, n_long, n_dclick);
    end
    checks++;
    if (t_short - t_release != DC) begin
      errors++;
      $display("[TB] FAIL short_delay got=%0d want=%0d", t_short - t_release, DC);
    end
  endtask

  task automatic test_long_press();
    logic q[$];
    reset_tally();
    repeat (20) q.push_back(1'b1);
    repeat (8) q.push_back(1'b0);
    foreach (q[i]) begin
      drive_cycle(1'b0, 1'b1, q[i]);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL long_trace cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    checks++;
    if (n_long != 1 || n_repeat != 3 || n_release != 1 || n_short != 0) begin
      errors++;
      $display("[TB] FAIL long_counts got l%0d rep%0d r%0d s%0d want l1 rep3 r1 s0",
               n_long, n_repeat, n_release, n_short);
    end
    checks++;
    if (t_long - t_press != LC) begin
      errors++;
      $display("[TB] FAIL long_delay got=%0d want=%0d", t_long - t_press, LC);
    end
  endtask

  task automatic test_double_click();
    logic q[$];
    reset_tally();
    repeat (2) q.push_back(1'b1);
    repeat (3) q.push_back(1'b0);
    repeat (2) q.push_back(1'b1);
    foreach (q[i]) begin
      drive_cycle(1'b0, 1'b1, q[i]);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL dclick_trace cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs[6] !== 1'b0 || obs[4] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dclick_held_drop got held=%b rel=%b want held=0 rel=1", obs[6], obs[4]);
    end
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL dclick_tail cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    checks++;
    if (n_press != 2 || n_dclick != 1 || n_short != 0 || n_release != 2 || t_dclick != t_press) begin
      errors++;
      $display("[TB] FAIL dclick_counts got p%0d d%0d s%0d r%0d want p2 d1 s0 r2 (dclick with 2nd press)",
               n_press, n_dclick, n_short, n_release);
    end
  endtask

  task automatic test_boundaries();
    logic q[$];
    reset_tally();
    repeat (LC) q.push_back(1'b1);
    repeat (12) q.push_back(1'b0);
    foreach (q[i]) begin
      drive_cycle(1'b0, 1'b1, q[i]);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL threshold_trace cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    checks++;
    if (n_long != 0 || n_short != 1) begin
      errors++;
      $display("[TB] FAIL threshold_counts got l%0d s%0d want l0 s1", n_long, n_short);
    end
    reset_tally();
    q.delete();
    q.push_back(1'b1);
    repeat (DC) q.push_back(1'b0);
    q.push_back(1'b1);
    repeat (10) q.push_back(1'b0);
    foreach (q[i]) begin
      drive_cycle(1'b0, 1'b1, q[i]);
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL expiry_trace cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    checks++;
    if (n_dclick != 1 || n_short != 0) begin
      errors++;
      $display("[TB] FAIL expiry_counts got d%0d s%0d want d1 s0", n_dclick, n_short);
    end
  endtask

  task automatic test_reset_held();
    reset_tally();
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b1);
    repeat (5) drive_cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (n_press != 0 || obs !== exp_vec || obs_n !== exp_vec) begin
      errors++;
      $display("[TB] FAIL held_through_reset got p%0d obs=%b obs_n=%b want p0 obs=%b",
               n_press, obs, obs_n, exp_vec);
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    repeat (5) drive_cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (n_press != 1 || obs !== exp_vec || obs_n !== exp_vec) begin
      errors++;
      $display("[TB] FAIL repress_after_reset got p%0d obs=%b want p1 obs=%b", n_press, obs, exp_vec);
    end
    reset_tally();
    drive_cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if (obs !== 7'b0 || obs_n !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold got=%b got_n=%b want=%b", obs, obs_n, 7'b0);
    end
    repeat (12) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (n_short != 0 || n_release != 0 || obs !== exp_vec) begin
      errors++;
      $display("[TB] FAIL reset_mid_tail got s%0d r%0d want s0 r0", n_short, n_release);
    end
  endtask

  task automatic test_enable();
    reset_tally();
    repeat (2) drive_cycle(1'b0, 1'b1, 1'b1);
    repeat (2) drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== 7'b0 || obs_n !== 7'b0) begin
        errors++;
        $display("[TB] FAIL disabled_outputs cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, 7'b0);
      end
    end
    repeat (10) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (n_short != 0 || n_release != 1) begin
      errors++;
      $display("[TB] FAIL enable_wait_short got s%0d r%0d want s0 r1", n_short, n_release);
    end
    reset_tally();
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b1);
    repeat (5) drive_cycle(1'b0, 1'b1, 1'b1);
    repeat (10) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (n_press != 0 || n_short != 0 || n_release != 0) begin
      errors++;
      $display("[TB] FAIL enable_held_press got p%0d s%0d r%0d want p0 s0 r0",
               n_press, n_short, n_release);
    end
  endtask

  task automatic test_random();
    int   dur;
    logic lvl, en, r;
    dur = 0; lvl = 1'b0; en = 1'b1; r = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (dur == 0) begin
        lvl = 1'($urandom_range(0, 1));
        dur = $urandom_range(1, 14);
        en  = ($urandom_range(0, 15) != 0);
        r   = ($urandom_range(0, 40) == 0);
      end
      drive_cycle(r, en, lvl);
      dur--;
      checks++;
      if (obs !== exp_vec || obs_n !== exp_vec) begin
        errors++;
        $display("[TB] FAIL random_trace cyc=%0d got=%b got_n=%b want=%b", cyc, obs, obs_n, exp_vec);
      end
    end
    repeat (12) drive_cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== exp_vec || obs_n !== exp_vec) begin
      errors++;
      $display("[TB] FAIL random_settle got=%b got_n=%b want=%b", obs, obs_n, exp_vec);
    end
  endtask

  initial begin
    rst_a_p = 1'b1;
    bus.enable = 1'b1;
    bus.btn_in = 1'b0;
    bus_n.enable = 1'b1;
    bus_n.btn_in = 1'b1;
    reset_tally();
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_boundaries();
    test_reset_held();
    test_enable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
